// File: rtl/jtag_cmd_sysclk_bridge.sv
// System-clock side of the debug JTAG bridge: synchronises update-DR/IR,
// captures the scanned register and issues one action strobe per scan.
module jtag_cmd_sysclk_bridge #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  localparam int NCMD       = 2**IR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vs_udr,
  input  logic                vs_uir,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [SR_WIDTH-1:0] sr,
  input  logic                action_ready,
  input  logic                clear_overrun,
  output logic [SR_WIDTH-1:0] jdo,
  output logic [IR_WIDTH-1:0] ir_q,
  output logic [NCMD-1:0]     take_action,
  output logic [NCMD-1:0]     take_no_action,
  output logic                cmd_pending,
  output logic                overrun
);

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic                   r_udr_d;
  logic                   r_uir_d;
  logic                   r_armed;
  logic [2:0]             r_fill;
  logic [SR_WIDTH-1:0]    r_jdo;
  logic [IR_WIDTH-1:0]    r_ir_q;
  logic [NCMD-1:0]        r_take_action;
  logic [NCMD-1:0]        r_take_no_action;
  logic                   r_cmd_pending;
  logic                   r_overrun;

  logic            w_udr_s;
  logic            w_uir_s;
  logic            w_udr_edge;
  logic            w_uir_edge;
  logic [NCMD-1:0] w_onehot;

  assign w_udr_s    = r_udr_sync[SYNC_STAGES-1];
  assign w_uir_s    = r_uir_sync[SYNC_STAGES-1];
  assign w_udr_edge = w_udr_s & ~r_udr_d & r_armed;
  assign w_uir_edge = w_uir_s & ~r_uir_d & r_armed;
  assign w_onehot   = NCMD'(1) << r_ir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_udr_sync       <= '0;
      r_uir_sync       <= '0;
      r_udr_d          <= 1'b0;
      r_uir_d          <= 1'b0;
      r_armed          <= 1'b0;
      r_fill           <= '0;
      r_jdo            <= '0;
      r_ir_q           <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
      r_cmd_pending    <= 1'b0;
      r_overrun        <= 1'b0;
    end else begin
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_d    <= w_udr_s;
      r_uir_d    <= w_uir_s;
      // Arm only once the chains hold real samples, so a level held
      // high through reset never looks like a fresh edge.
      if (r_fill != 3'(SYNC_STAGES))
        r_fill <= r_fill + 3'd1;
      else if (!w_udr_s && !w_uir_s)
        r_armed <= 1'b1;

      r_take_action    <= '0;
      r_take_no_action <= '0;

      unique case (r_state)
        S_IDLE: begin
          if (w_udr_edge && !w_uir_edge) begin
            r_jdo         <= sr;
            r_ir_q        <= ir_in;
            r_cmd_pending <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_uir_edge) begin
            r_cmd_pending <= 1'b0;
            r_state       <= S_IDLE;
          end else if (action_ready) begin
            if (r_jdo[SR_WIDTH-1])
              r_take_action <= w_onehot;
            else
              r_take_no_action <= w_onehot;
            r_cmd_pending <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
      endcase

      if (r_state == S_ISSUE && w_udr_edge && !w_uir_edge)
        r_overrun <= 1'b1;
      else if (clear_overrun)
        r_overrun <= 1'b0;
    end
  end

  assign jdo            = r_jdo;
  assign ir_q           = r_ir_q;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign cmd_pending    = r_cmd_pending;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_jtag_cmd_sysclk_bridge.sv
// Directed bench for jtag_cmd_sysclk_bridge: default build plus a
// wide/deep-sync build sharing clock and reset.
module tb_jtag_cmd_sysclk_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        vs_udr, vs_uir;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        action_ready, clear_overrun;
  logic [37:0] jdo;
  logic [1:0]  ir_q;
  logic [3:0]  take_action, take_no_action;
  logic        cmd_pending, overrun;

  logic        vs_udr2, vs_uir2;
  logic [2:0]  ir_in2;
  logic [43:0] sr2;
  logic        action_ready2, clear_overrun2;
  logic [43:0] jdo2;
  logic [2:0]  ir_q2;
  logic [7:0]  take_action2, take_no_action2;
  logic        cmd_pending2, overrun2;

  jtag_cmd_sysclk_bridge dut (
    .clk            (clk),
    .reset          (reset),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .sr             (sr),
    .action_ready   (action_ready),
    .clear_overrun  (clear_overrun),
    .jdo            (jdo),
    .ir_q           (ir_q),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .cmd_pending    (cmd_pending),
    .overrun        (overrun)
  );

  jtag_cmd_sysclk_bridge #(
    .SR_WIDTH    (44),
    .IR_WIDTH    (3),
    .SYNC_STAGES (4)
  ) dut2 (
    .clk            (clk),
    .reset          (reset),
    .vs_udr         (vs_udr2),
    .vs_uir         (vs_uir2),
    .ir_in          (ir_in2),
    .sr             (sr2),
    .action_ready   (action_ready2),
    .clear_overrun  (clear_overrun2),
    .jdo            (jdo2),
    .ir_q           (ir_q2),
    .take_action    (take_action2),
    .take_no_action (take_no_action2),
    .cmd_pending    (cmd_pending2),
    .overrun        (overrun2)
  );

  int n_chk = 0;
  int n_err = 0;
  logic seen;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    vs_udr = 0; vs_uir = 0; ir_in = '0; sr = '0;
    action_ready = 1'b1; clear_overrun = 1'b0;
    vs_udr2 = 0; vs_uir2 = 0; ir_in2 = '0; sr2 = '0;
    action_ready2 = 1'b1; clear_overrun2 = 1'b0;
    tick(3);
    chk("rst_jdo", 64'(jdo), 64'h0);
    chk("rst_irq", 64'(ir_q), 64'h0);
    chk("rst_strb", 64'({take_action, take_no_action}), 64'h0);
    chk("rst_pend", 64'(cmd_pending), 64'h0);
    chk("rst_ovr", 64'(overrun), 64'h0);
    reset = 1'b0;
    tick(5);

    // Basic action scan, ready held high
    sr = 38'h20_0000_1234; ir_in = 2'd1; vs_udr = 1'b1;
    tick(2);
    chk("t1_jdo_early", 64'(jdo), 64'h0);
    tick(1);
    chk("t1_jdo", 64'(jdo), 64'h20_0000_1234);
    chk("t1_irq", 64'(ir_q), 64'h1);
    chk("t1_ta_early", 64'(take_action), 64'h0);
    tick(1);
    chk("t1_ta", 64'(take_action), 64'h2);
    chk("t1_tna", 64'(take_no_action), 64'h0);
    chk("t1_pend", 64'(cmd_pending), 64'h0);
    tick(1);
    chk("t1_ta_off", 64'(take_action), 64'h0);
    tick(1);
    vs_udr = 1'b0;
    tick(4);

    // No-action scan waiting on ready
    action_ready = 1'b0;
    sr = 38'h1F_DEAD_BEEF; ir_in = 2'd3; vs_udr = 1'b1;
    tick(3);
    chk("t2_jdo", 64'(jdo), 64'h1F_DEAD_BEEF);
    chk("t2_pend0", 64'(cmd_pending), 64'h1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (i == 2) vs_udr = 1'b0;
      chk("t2_pend", 64'(cmd_pending), 64'h1);
      chk("t2_nostrb", 64'({take_action, take_no_action}), 64'h0);
    end
    action_ready = 1'b1;
    tick(1);
    chk("t2_tna", 64'(take_no_action), 64'h8);
    chk("t2_ta", 64'(take_action), 64'h0);
    chk("t2_pend_clr", 64'(cmd_pending), 64'h0);
    tick(1);
    chk("t2_tna_off", 64'(take_no_action), 64'h0);
    tick(3);

    // Overrun: second scan while first is pending
    action_ready = 1'b0;
    sr = 38'h3F_0000_00C3; ir_in = 2'd0; vs_udr = 1'b1;
    tick(6); vs_udr = 1'b0; tick(3);
    sr = 38'h00_1111_2222; ir_in = 2'd2; vs_udr = 1'b1;
    tick(3);
    chk("t3_ovr", 64'(overrun), 64'h1);
    chk("t3_jdo", 64'(jdo), 64'h3F_0000_00C3);
    chk("t3_irq", 64'(ir_q), 64'h0);
    chk("t3_pend", 64'(cmd_pending), 64'h1);
    tick(3); vs_udr = 1'b0; tick(3);
    action_ready = 1'b1;
    tick(1);
    chk("t3_ta", 64'(take_action), 64'h1);
    chk("t3_ovr_hold", 64'(overrun), 64'h1);
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    chk("t3_ovr_clr", 64'(overrun), 64'h0);

    // Overrun set coincident with clear
    action_ready = 1'b0;
    sr = 38'h00_0000_0055; ir_in = 2'd1; vs_udr = 1'b1;
    tick(6); vs_udr = 1'b0; tick(3);
    sr = 38'h3F_FFFF_FFFF; ir_in = 2'd3; vs_udr = 1'b1;
    tick(2);
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    chk("t3_ovr_win", 64'(overrun), 64'h1);
    chk("t3_jdo_keep", 64'(jdo), 64'h00_0000_0055);
    tick(3); vs_udr = 1'b0; tick(3);
    action_ready = 1'b1;
    tick(1);
    chk("t3_tna", 64'(take_no_action), 64'h2);
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    chk("t3_ovr_clr2", 64'(overrun), 64'h0);

    // Abort via update-IR while pending
    action_ready = 1'b0;
    sr = 38'h2A_AAAA_5555; ir_in = 2'd2; vs_udr = 1'b1;
    tick(6); vs_udr = 1'b0; tick(3);
    chk("t4_pend", 64'(cmd_pending), 64'h1);
    vs_uir = 1'b1;
    tick(2);
    chk("t4_pend_m1", 64'(cmd_pending), 64'h1);
    tick(1);
    chk("t4_abort", 64'(cmd_pending), 64'h0);
    seen = 1'b0;
    tick(3); vs_uir = 1'b0;
    action_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen = seen | (|{take_action, take_no_action});
    end
    chk("t4_nostrb", 64'(seen), 64'h0);
    chk("t4_jdo", 64'(jdo), 64'h2A_AAAA_5555);

    // Level held high through reset
    reset = 1'b1;
    sr = 38'h24_6802_4680; ir_in = 2'd1; vs_udr = 1'b1;
    tick(3);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen = seen | (|{take_action, take_no_action});
    end
    chk("t5_jdo", 64'(jdo), 64'h0);
    chk("t5_pend", 64'(cmd_pending), 64'h0);
    chk("t5_nostrb", 64'(seen), 64'h0);
    vs_udr = 1'b0;
    tick(4);
    vs_udr = 1'b1;
    tick(3);
    chk("t5_jdo_cap", 64'(jdo), 64'h24_6802_4680);
    tick(1);
    chk("t5_ta", 64'(take_action), 64'h2);
    tick(2); vs_udr = 1'b0; tick(3);

    // Wide build, four sync stages
    sr2 = 44'h800_0000_0001; ir_in2 = 3'd6; vs_udr2 = 1'b1;
    tick(5);
    chk("t6_jdo", 64'(jdo2), 64'h800_0000_0001);
    chk("t6_ta_early", 64'(take_action2), 64'h0);
    tick(1);
    chk("t6_ta", 64'(take_action2), 64'h40);
    chk("t6_tna", 64'(take_no_action2), 64'h0);
    tick(1);
    chk("t6_ta_off", 64'(take_action2), 64'h0);
    vs_udr2 = 1'b0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_cmd_sysclk_bridge.md
Name: jtag_cmd_sysclk_bridge

Overview:
- System-clock half of the Nios II on-chip debug JTAG bridge, generalised over shift-register width, IR width and synchroniser depth.
- Synchronises the virtual-JTAG update-DR/update-IR events from the TCK domain and captures the scanned shift register into jdo.
- Issues exactly one take_action or take_no_action strobe per scan, selected by the captured IR code.
- Adds a consumer ready handshake, uir-driven abort and sticky overrun detection, none of which the previous generation has.

Parameters:
SR_WIDTH, 38, width of the scanned shift register and of jdo; bit SR_WIDTH-1 is the action flag
IR_WIDTH, 2, virtual IR width; number of command channels NCMD = 2**IR_WIDTH
SYNC_STAGES, 2, synchroniser flops on vs_udr/vs_uir (legal 2..4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
vs_udr  in  1  virtual update-DR level from TCK domain (asynchronous)
vs_uir  in  1  virtual update-IR level from TCK domain (asynchronous)
ir_in  in  IR_WIDTH  virtual IR; quasi-static, stable while vs_udr is high
sr  in  SR_WIDTH  TCK-domain shift register; stable while vs_udr is high
action_ready  in  1  consumer can accept a strobe this cycle
clear_overrun  in  1  clears the overrun flag
jdo  out  SR_WIDTH  captured shift register
ir_q  out  IR_WIDTH  captured IR code
take_action  out  NCMD  one-hot strobe, channel ir_q, action flag = 1
take_no_action  out  NCMD  one-hot strobe, channel ir_q, action flag = 0
cmd_pending  out  1  a captured command is awaiting action_ready
overrun  out  1  sticky: an update-DR event arrived while a command was pending

Behaviour:
- Reset: jdo=0, ir_q=0, all strobes 0, cmd_pending=0, overrun=0, sync chains=0, armed=0, state=IDLE.
- Synchronisers: each of vs_udr and vs_uir passes through SYNC_STAGES flops to udr_s/uir_s; one further flop gives udr_d/uir_d.
  - udr_edge = udr_s & ~udr_d & armed; uir_edge = uir_s & ~uir_d & armed.
- armed is set the first cycle both udr_s==0 and uir_s==0 after reset. A level held high through reset therefore produces no event.
- FSM IDLE:
  - on udr_edge (and no uir_edge): jdo<=sr, ir_q<=ir_in, go to ISSUE.
  - on uir_edge: stay in IDLE, no capture.
- FSM ISSUE: cmd_pending=1.
  - If action_ready=1 (and no uir_edge): next cycle assert take_action[ir_q] if jdo[SR_WIDTH-1]=1, else take_no_action[ir_q]. The strobe is registered, exactly one cycle wide, and the FSM returns to IDLE in the same edge.
  - If uir_edge: abort, return to IDLE, no strobe, jdo retained.
  - If udr_edge: overrun<=1, new command dropped, jdo/ir_q unchanged.
- Precedence:
  - uir_edge beats udr_edge and beats action_ready in the same cycle.
  - overrun set beats clear_overrun in the same cycle.
- Latency: vs_udr rising sampled at edge k → jdo valid after edge k+SYNC_STAGES. With action_ready held high, the strobe is high during the cycle after edge k+SYNC_STAGES+1.
- A strobe cycle and a new udr_edge may coincide: the FSM is in IDLE then, so the new command is captured normally, with no overrun.
- At most one bit of take_action|take_no_action is high in any cycle. All outputs are registered, with no combinational input-to-output paths.
- Reset mid-ISSUE drops the command silently; overrun is cleared.

Test Plan:
- SR_WIDTH=38, IR_WIDTH=2, SYNC_STAGES=2, action_ready=1; pulse vs_udr 6 cycles with sr=38'h20_0000_1234, ir_in=2'd1 → jdo=38'h20_0000_1234 after edge k+2; take_action=4'b0010 for exactly one cycle after edge k+3; take_no_action stays 0.
- Same scan with sr[37]=0, ir_in=2'd3, action_ready held 0 for 10 cycles, then 1 → cmd_pending=1 throughout; take_no_action=4'b1000 exactly one cycle after ready is sampled high; cmd_pending then 0.
- action_ready=0, two vs_udr pulses with sr=A then sr=B → overrun=1, jdo=A, one strobe for A after ready rises. Then clear_overrun=1 → overrun=0 next cycle. A clear coincident with a third overrun leaves overrun=1.
- In ISSUE, pulse vs_uir → cmd_pending=0 SYNC_STAGES+1 cycles later; no strobe ever fires; jdo unchanged.
- Hold vs_udr=1 across reset deassertion → no capture, no strobe. After vs_udr goes low then high, a normal capture occurs.
- SYNC_STAGES=4, IR_WIDTH=3, SR_WIDTH=44, ir_in=3'd6, sr[43]=1 → take_action=8'b0100_0000 one cycle after edge k+5.
